// File: rtl/expr_vector_sequencer.sv
// Drives LFSR operand vectors into a wrapped expression datapath and compacts each
// 90-bit result into a 32-bit MISR signature that is checked against a golden value.
module expr_vector_sequencer #(
    parameter int          LAT       = 0,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [31:0]      seed,
    input  logic [31:0]      expected_sig,
    output logic [29:0]      a_bus,
    output logic [29:0]      b_bus,
    input  logic [89:0]      y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature,
    output logic [CNT_W-1:0] vec_count
);
    localparam int            WW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WW-1:0] LAT_V = WW'(LAT);

    // Handshake: start is a level sampled only in IDLE/DONE; abort cancels a run
    // on the next edge and wins over both start and a pending sample.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] num_q;
    logic [63:0]      lfsr, lfsr_nx, lfsr_seed;
    logic [WW-1:0]    wait_cnt;
    logic             sample, last, launch;
    logic [31:0]      fold, sig_nx;

    assign lfsr_seed = {seed, ~seed};
    assign lfsr_nx   = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    assign sample    = (state == RUN) && (wait_cnt == LAT_V);
    assign last      = sample && ((vec_count + CNT_W'(1)) == num_q);
    assign launch    = (state != RUN) && start && !abort;
    assign fold      = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
    assign sig_nx    = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ fold;

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (signature == expected_sig);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (abort)      state_nx = IDLE;
                else if (start) state_nx = (num_vectors == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The first vector is the seed image itself; the LFSR steps only between vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q     <= '0;
            lfsr      <= '0;
            a_bus     <= '0;
            b_bus     <= '0;
            wait_cnt  <= '0;
            signature <= 32'hFFFFFFFF;
            vec_count <= '0;
        end else if (launch) begin
            num_q     <= num_vectors;
            signature <= 32'hFFFFFFFF;
            vec_count <= '0;
            if (num_vectors != '0) begin
                lfsr     <= lfsr_seed;
                a_bus    <= lfsr_seed[29:0];
                b_bus    <= lfsr_seed[59:30];
                wait_cnt <= '0;
            end
        end else if (sample && !abort) begin
            signature <= sig_nx;
            vec_count <= vec_count + CNT_W'(1);
            if (!last) begin
                lfsr     <= lfsr_nx;
                a_bus    <= lfsr_nx[29:0];
                b_bus    <= lfsr_nx[59:30];
                wait_cnt <= '0;
            end
        end else if (state == RUN && !abort) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
endmodule
